// File: rtl/spi_dual_requester_arbiter.sv
// Two-requester SPI master: round-robin grant per transaction, mode-0 byte engine,
// multi-byte transactions kept under one chip-select while the owner holds 'hold'.
module spi_dual_requester_arbiter #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2,
    parameter int unsigned IDLE_GAP = 1
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic [1:0] req,
    input  logic [1:0] hold,
    input  logic [7:0] tx_data0,
    input  logic [7:0] tx_data1,
    output logic [1:0] ack,
    output logic [1:0] done,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       spi_SCLK,
    output logic       spi_MOSI,
    input  logic       spi_MISO,
    output logic [1:0] spi_SS_n
);

    typedef enum logic [2:0] {
        StIdle, StSetup, StShift, StNext, StWait, StCsHold, StGap
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        sclk_q, sclk_d;
    logic [7:0]  tx_sh_q, tx_sh_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic [1:0]  ss_n_q, ss_n_d;
    logic        owner_q, owner_d;
    logic        last_grant_q, last_grant_d;
    logic [1:0]  ack_q, ack_d;
    logic [1:0]  done_q, done_d;

    logic       grant;
    logic [1:0] owner_oh;
    logic [7:0] owner_tx;

    // On a tie the requester that did not win last time is granted.
    assign grant    = (req == 2'b11) ? ~last_grant_q : req[1];
    assign owner_oh = owner_q ? 2'b10 : 2'b01;
    assign owner_tx = owner_q ? tx_data1 : tx_data0;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_cnt_d    = bit_cnt_q;
        sclk_d       = sclk_q;
        tx_sh_d      = tx_sh_q;
        rx_sh_d      = rx_sh_q;
        rx_data_d    = rx_data_q;
        ss_n_d       = ss_n_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        ack_d        = 2'b00;
        done_d       = 2'b00;

        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    owner_d      = grant;
                    last_grant_d = grant;
                    tx_sh_d      = grant ? tx_data1 : tx_data0;
                    ack_d        = grant ? 2'b10 : 2'b01;
                    ss_n_d       = grant ? 2'b01 : 2'b10;
                    cnt_d        = '0;
                    state_d      = StSetup;
                end
            end
            StSetup: begin
                if (cnt_q == 16'(CS_SETUP - 1)) begin
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = StShift;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StShift: begin
                if (cnt_q == 16'(CLK_DIV - 1)) begin
                    cnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d  = 1'b1;
                        rx_sh_d = {rx_sh_q[6:0], spi_MISO};
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_d = rx_sh_q;
                            done_d    = owner_oh;
                            state_d   = StNext;
                        end else begin
                            tx_sh_d   = {tx_sh_q[6:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StNext, StWait: begin
                if (hold[owner_q]) begin
                    if (req[owner_q]) begin
                        // Follow-on byte starts shifting at once: CS is already set up.
                        tx_sh_d   = owner_tx;
                        ack_d     = owner_oh;
                        cnt_d     = '0;
                        bit_cnt_d = '0;
                        state_d   = StShift;
                    end else begin
                        state_d = StWait;
                    end
                end else begin
                    cnt_d   = '0;
                    state_d = StCsHold;
                end
            end
            StCsHold: begin
                if (cnt_q == 16'(CS_HOLD - 1)) begin
                    cnt_d   = '0;
                    ss_n_d  = 2'b11;
                    state_d = StGap;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StGap: begin
                if (cnt_q == 16'(IDLE_GAP - 1)) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            bit_cnt_q    <= '0;
            sclk_q       <= 1'b0;
            tx_sh_q      <= '0;
            rx_sh_q      <= '0;
            rx_data_q    <= '0;
            ss_n_q       <= 2'b11;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            ack_q        <= '0;
            done_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            sclk_q       <= sclk_d;
            tx_sh_q      <= tx_sh_d;
            rx_sh_q      <= rx_sh_d;
            rx_data_q    <= rx_data_d;
            ss_n_q       <= ss_n_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            ack_q        <= ack_d;
            done_q       <= done_d;
        end
    end

    assign ack      = ack_q;
    assign done     = done_q;
    assign rx_data  = rx_data_q;
    assign busy     = (state_q != StIdle);
    assign spi_SCLK = sclk_q;
    assign spi_MOSI = tx_sh_q[7];
    assign spi_SS_n = ss_n_q;

endmodule

// File: tb/tb_spi_dual_requester_arbiter.sv
// Directed bench for spi_dual_requester_arbiter: scoreboard of {done, rx_data} expectations
// plus per-cycle bus monitors (SCLK rises, MOSI bits, chip-select occupancy).
module tb_spi_dual_requester_arbiter;

    logic       clk_clk       = 1'b0;
    logic       reset_reset_n = 1'b0;
    logic [1:0] req           = 2'b00;
    logic [1:0] hold          = 2'b00;
    logic [7:0] tx_data0      = 8'h00;
    logic [7:0] tx_data1      = 8'h00;
    logic [1:0] ack;
    logic [1:0] done;
    logic [7:0] rx_data;
    logic       busy;
    logic       spi_SCLK;
    logic       spi_MOSI;
    logic       spi_MISO;
    logic [1:0] spi_SS_n;
    int         miso_mode = 0;  // 0: loopback, 1: tied high, 2: tied low

    spi_dual_requester_arbiter #(
        .CLK_DIV (2),
        .CS_SETUP(2),
        .CS_HOLD (2),
        .IDLE_GAP(1)
    ) dut (
        .clk_clk      (clk_clk),
        .reset_reset_n(reset_reset_n),
        .req          (req),
        .hold         (hold),
        .tx_data0     (tx_data0),
        .tx_data1     (tx_data1),
        .ack          (ack),
        .done         (done),
        .rx_data      (rx_data),
        .busy         (busy),
        .spi_SCLK     (spi_SCLK),
        .spi_MOSI     (spi_MOSI),
        .spi_MISO     (spi_MISO),
        .spi_SS_n     (spi_SS_n)
    );

    always #5 clk_clk = ~clk_clk;

    assign spi_MISO = (miso_mode == 0) ? spi_MOSI : (miso_mode == 1);

    int          vectors = 0;
    int          errors  = 0;
    int          sclk_rises, ss_low, ss1_low, ss1_falls, acks0, acks1;
    logic [23:0] mosi_bits;
    logic        sclk_prev = 1'b0;
    logic        ss1_prev  = 1'b1;
    logic [9:0]  sb[$];
    logic [1:0]  first_ack;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        sclk_rises = 0;
        ss_low     = 0;
        ss1_low    = 0;
        ss1_falls  = 0;
        acks0      = 0;
        acks1      = 0;
        mosi_bits  = '0;
    endtask

    task automatic step();
        logic [9:0] e;
        @(negedge clk_clk);
        if (spi_SCLK && !sclk_prev) begin
            sclk_rises++;
            mosi_bits = {mosi_bits[22:0], spi_MOSI};
        end
        sclk_prev = spi_SCLK;
        if (spi_SS_n != 2'b11) ss_low++;
        if (!spi_SS_n[1]) begin
            ss1_low++;
            if (ss1_prev) ss1_falls++;
        end
        ss1_prev = spi_SS_n[1];
        if (ack[0]) acks0++;
        if (ack[1]) acks1++;
        chk("cs_exclusive", 32'(spi_SS_n == 2'b00), 32'(0));
        chk("ack_exclusive", 32'(ack == 2'b11), 32'(0));
        chk("done_exclusive", 32'(done == 2'b11), 32'(0));
        if (done != 2'b00) begin
            if (sb.size() == 0) begin
                chk("done_unexpected", 32'(done), 32'(0));
            end else begin
                e = sb.pop_front();
                chk("done_rx", 32'({done, rx_data}), 32'(e));
            end
        end
    endtask

    task automatic wait_ack(input int n, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            step();
            if (ack[n]) break;
        end
        if (i == budget) chk("ack_timeout", 32'(0), 32'(1));
    endtask

    task automatic wait_any_ack(output logic [1:0] a, input int budget);
        int i;
        a = 2'b00;
        for (i = 0; i < budget; i++) begin
            step();
            if (ack != 2'b00) break;
        end
        if (i == budget) chk("any_ack_timeout", 32'(0), 32'(1));
        else a = ack;
    endtask

    task automatic wait_done(input int n, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            step();
            if (done[n]) break;
        end
        if (i == budget) chk("done_timeout", 32'(0), 32'(1));
    endtask

    task automatic wait_idle(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            step();
            if (!busy) break;
        end
        if (i == budget) chk("idle_timeout", 32'(0), 32'(1));
    endtask

    initial begin
        clear_mon();
        repeat (3) step();
        chk("rst_ss", 32'(spi_SS_n), 32'(2'b11));
        chk("rst_sclk", 32'(spi_SCLK), 32'(0));
        chk("rst_mosi", 32'(spi_MOSI), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_ack_done", 32'({ack, done}), 32'(0));
        chk("rst_rx", 32'(rx_data), 32'(0));
        reset_reset_n = 1'b1;
        step();

        // Single byte from requester 0, loopback.
        clear_mon();
        tx_data0 = 8'hA5;
        req      = 2'b01;
        sb.push_back({2'b01, 8'hA5});
        wait_ack(0, 10);
        req = 2'b00;
        wait_idle(200);
        chk("t1_sclk", 32'(sclk_rises), 32'(8));
        chk("t1_mosi", 32'(mosi_bits[7:0]), 32'(8'hA5));
        chk("t1_ss_low", 32'(ss_low), 32'(37));
        chk("t1_acks", 32'(acks0), 32'(1));
        chk("t1_rx", 32'(rx_data), 32'(8'hA5));
        chk("t1_sb", 32'(sb.size()), 32'(0));

        // Tie right after reset: requester 0 first.
        reset_reset_n = 1'b0;
        step();
        reset_reset_n = 1'b1;
        step();
        tx_data0 = 8'h3C;
        tx_data1 = 8'hC3;
        req      = 2'b11;
        sb.push_back({2'b01, 8'h3C});
        sb.push_back({2'b10, 8'hC3});
        wait_any_ack(first_ack, 10);
        chk("t2_first", 32'(first_ack), 32'(2'b01));
        req[0] = 1'b0;
        wait_ack(1, 300);
        req[1] = 1'b0;
        wait_idle(200);
        // Requester 1 won last, so the next tie goes to 0.
        tx_data0 = 8'h0F;
        tx_data1 = 8'hF0;
        req      = 2'b11;
        sb.push_back({2'b01, 8'h0F});
        sb.push_back({2'b10, 8'hF0});
        wait_any_ack(first_ack, 10);
        chk("t2_tie_to0", 32'(first_ack), 32'(2'b01));
        req[0] = 1'b0;
        wait_ack(1, 300);
        req[1] = 1'b0;
        wait_idle(200);
        // Requester 0 wins alone, so the next tie goes to 1.
        tx_data0 = 8'h81;
        req      = 2'b01;
        sb.push_back({2'b01, 8'h81});
        wait_ack(0, 10);
        req = 2'b00;
        wait_idle(200);
        tx_data0 = 8'h42;
        tx_data1 = 8'h24;
        req      = 2'b11;
        sb.push_back({2'b10, 8'h24});
        sb.push_back({2'b01, 8'h42});
        wait_any_ack(first_ack, 10);
        chk("t2_tie_to1", 32'(first_ack), 32'(2'b10));
        req[1] = 1'b0;
        wait_ack(0, 300);
        req[0] = 1'b0;
        wait_idle(200);
        chk("t2_sb", 32'(sb.size()), 32'(0));

        // Three-byte held transaction on requester 1; requester 0 waits its turn.
        clear_mon();
        tx_data1 = 8'h11;
        hold     = 2'b10;
        req      = 2'b10;
        sb.push_back({2'b10, 8'h11});
        sb.push_back({2'b10, 8'h22});
        sb.push_back({2'b10, 8'h33});
        sb.push_back({2'b01, 8'h77});
        wait_ack(1, 10);
        tx_data1 = 8'h22;
        tx_data0 = 8'h77;
        req[0]   = 1'b1;
        wait_ack(1, 100);
        tx_data1 = 8'h33;
        wait_ack(1, 100);
        hold   = 2'b00;
        req[1] = 1'b0;
        wait_ack(0, 200);
        req[0] = 1'b0;
        chk("t3_sclk", 32'(sclk_rises), 32'(24));
        chk("t3_mosi", 32'(mosi_bits), 32'(24'h112233));
        chk("t3_ss1_low", 32'(ss1_low), 32'(103));
        chk("t3_ss1_falls", 32'(ss1_falls), 32'(1));
        chk("t3_acks1", 32'(acks1), 32'(3));
        wait_idle(200);
        chk("t3_sb", 32'(sb.size()), 32'(0));

        // Held transaction stalls in WAIT, then resumes without CS setup.
        clear_mon();
        tx_data0 = 8'h96;
        hold     = 2'b01;
        req      = 2'b01;
        sb.push_back({2'b01, 8'h96});
        sb.push_back({2'b01, 8'h5A});
        wait_ack(0, 10);
        req = 2'b00;
        wait_done(0, 100);
        repeat (20) begin
            step();
            chk("t4_wait_ss", 32'(spi_SS_n), 32'(2'b10));
            chk("t4_wait_sclk", 32'(spi_SCLK), 32'(0));
            chk("t4_wait_busy", 32'(busy), 32'(1));
        end
        tx_data0 = 8'h5A;
        req      = 2'b01;
        wait_ack(0, 2);
        req  = 2'b00;
        hold = 2'b00;
        wait_idle(200);
        chk("t4_sclk", 32'(sclk_rises), 32'(16));
        chk("t4_acks0", 32'(acks0), 32'(2));
        chk("t4_sb", 32'(sb.size()), 32'(0));

        // Asynchronous reset in the middle of a byte.
        clear_mon();
        tx_data1 = 8'hF0;
        req      = 2'b10;
        wait_ack(1, 10);
        req = 2'b00;
        for (int i = 0; i < 100; i++) begin
            step();
            if (sclk_rises == 4) break;
        end
        chk("t5_pre_sclk", 32'(spi_SCLK), 32'(1));
        chk("t5_pre_mosi", 32'(spi_MOSI), 32'(1));
        #2 reset_reset_n = 1'b0;
        #1;
        chk("t5_ss", 32'(spi_SS_n), 32'(2'b11));
        chk("t5_sclk", 32'(spi_SCLK), 32'(0));
        chk("t5_mosi", 32'(spi_MOSI), 32'(0));
        chk("t5_busy", 32'(busy), 32'(0));
        chk("t5_ack_done", 32'({ack, done}), 32'(0));
        repeat (3) step();
        reset_reset_n = 1'b1;
        step();
        tx_data1 = 8'hC5;
        req      = 2'b10;
        sb.push_back({2'b10, 8'hC5});
        wait_ack(1, 10);
        req = 2'b00;
        wait_idle(200);
        chk("t5_rx", 32'(rx_data), 32'(8'hC5));
        chk("t5_sb", 32'(sb.size()), 32'(0));

        // MISO tied high then low; tx chosen opposite so loopback would be caught.
        for (int m = 1; m <= 2; m++) begin
            miso_mode = m;
            tx_data0  = (m == 1) ? 8'h00 : 8'hFF;
            req       = 2'b01;
            sb.push_back({2'b01, (m == 1) ? 8'hFF : 8'h00});
            wait_ack(0, 10);
            req = 2'b00;
            wait_idle(200);
            chk("t6_rx", 32'(rx_data), 32'((m == 1) ? 8'hFF : 8'h00));
        end
        chk("t6_sb", 32'(sb.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
